// File: rtl/div_scheduler.sv
// Round-robin front end that shares one sequential divider among NUM_REQ clients.
// Optional macro DIV_ZERO_BYPASS_EN answers zero-divisor requests locally without using the divider.
module div_scheduler #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     div_start,
    output logic [WIDTH-1:0]         div_dividend,
    output logic [WIDTH-1:0]         div_divisor,
    input  logic                     div_ready,
    input  logic [WIDTH-1:0]         div_quotient,
    input  logic [WIDTH-1:0]         div_remainder,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_quotient,
    output logic [WIDTH-1:0]         rsp_remainder,
    output logic                     rsp_err
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] last_id;
    logic [1:0]      busy_cnt;
    logic            gnt_found;
    logic [ID_W-1:0] gnt_id;
    logic [WIDTH-1:0] gnt_dividend;
    logic [WIDTH-1:0] gnt_divisor;
`ifdef DIV_ZERO_BYPASS_EN
    logic            zero_byp;
`endif

    // Search starts one past the last winner so every client gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!gnt_found && req[(int'(last_id) + k) % NUM_REQ]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'((int'(last_id) + k) % NUM_REQ);
            end
        end
        gnt_dividend = req_dividend[int'(gnt_id)*WIDTH +: WIDTH];
        gnt_divisor  = req_divisor[int'(gnt_id)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_id       <= ID_W'(NUM_REQ - 1);
            busy_cnt      <= '0;
            ack           <= '0;
            div_start     <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
`ifdef DIV_ZERO_BYPASS_EN
            rsp_err       <= 1'b0;
            zero_byp      <= 1'b0;
`endif
        end else begin
            ack       <= '0;
            div_start <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_found && div_ready) begin
                        ack          <= NUM_REQ'(1) << gnt_id;
                        last_id      <= gnt_id;
                        div_dividend <= gnt_dividend;
                        div_divisor  <= gnt_divisor;
`ifdef DIV_ZERO_BYPASS_EN
                        if (gnt_divisor == '0) begin
                            zero_byp <= 1'b1;
                            state    <= RESP;
                        end else begin
                            state    <= ISSUE;
                        end
`else
                        state        <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    div_start <= 1'b1;
                    busy_cnt  <= '0;
                    state     <= WAIT_BUSY;
                end
                // A divider that never drops ready missed the start; pulse it again.
                WAIT_BUSY: begin
                    if (!div_ready)
                        state <= WAIT_DONE;
                    else if (busy_cnt == 2'd3)
                        state <= ISSUE;
                    else
                        busy_cnt <= busy_cnt + 2'd1;
                end
                WAIT_DONE: begin
                    if (div_ready) begin
                        rsp_valid     <= 1'b1;
                        rsp_id        <= last_id;
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
`ifdef DIV_ZERO_BYPASS_EN
                        rsp_err       <= 1'b0;
`endif
                        state         <= RESP;
                    end
                end
                RESP: begin
`ifdef DIV_ZERO_BYPASS_EN
                    // Bypassed responses are published here, one cycle after the ack.
                    if (zero_byp) begin
                        zero_byp      <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_id        <= last_id;
                        rsp_quotient  <= '1;
                        rsp_remainder <= div_dividend;
                        rsp_err       <= 1'b1;
                    end
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef DIV_ZERO_BYPASS_EN
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a behavioural multi-cycle divider model.
// Covers arbitration order, latencies, busy gating, reset mid-flight, start re-issue, zero divisor.
module tb_div_scheduler;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int LAT     = 9;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_dividend;
    logic [NUM_REQ*WIDTH-1:0] req_divisor;
    logic [NUM_REQ-1:0]       ack;
    logic                     div_start;
    logic [WIDTH-1:0]         div_dividend;
    logic [WIDTH-1:0]         div_divisor;
    logic                     div_ready;
    logic [WIDTH-1:0]         div_quotient;
    logic [WIDTH-1:0]         div_remainder;
    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_quotient;
    logic [WIDTH-1:0]         rsp_remainder;
    logic                     rsp_err;

    logic force_busy = 1'b0;
    logic stuck      = 1'b0;

    div_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .ack(ack), .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Divider model: drops ready for LAT cycles after an accepted start.
    logic             m_ready, m_busy;
    int               m_cnt;
    logic [WIDTH-1:0] m_q, m_r;
    assign div_ready     = m_ready & ~force_busy;
    assign div_quotient  = m_q;
    assign div_remainder = m_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready <= 1'b1; m_busy <= 1'b0; m_cnt <= 0; m_q <= '0; m_r <= '0;
        end else if (!m_busy) begin
            if (div_start && !stuck) begin
                m_busy  <= 1'b1;
                m_ready <= 1'b0;
                m_cnt   <= LAT;
                if (div_divisor == '0) begin
                    m_q <= '1; m_r <= div_dividend;
                end else begin
                    m_q <= div_dividend / div_divisor; m_r <= div_dividend % div_divisor;
                end
            end
        end else if (m_cnt == 1) begin
            m_busy <= 1'b0; m_ready <= 1'b1;
        end else begin
            m_cnt <= m_cnt - 1;
        end
    end

    // Event monitor: logs grants, starts and responses with their cycle numbers.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ack_cnt = 0, start_cnt = 0, rsp_cnt = 0, overlap = 0, bad_oh = 0, ready_rise = 0;
    logic ready_prev = 1'b1;
    int               ack_cyc[64], start_cyc[64], rsp_cyc[64];
    logic [ID_W-1:0]  gnt_log[64], rid_log[64];
    logic [WIDTH-1:0] q_log[64], r_log[64];
    logic             err_log[64];

    function automatic logic [ID_W-1:0] oh2id(input logic [NUM_REQ-1:0] oh);
        logic [ID_W-1:0] id = '0;
        for (int i = 0; i < NUM_REQ; i++) if (oh[i]) id = ID_W'(i);
        return id;
    endfunction

    always @(negedge clk) begin
        ready_prev <= div_ready;
        if (div_ready && !ready_prev) ready_rise <= cyc;
        if (ack != '0) begin
            ack_cyc[ack_cnt & 63] <= cyc;
            gnt_log[ack_cnt & 63] <= oh2id(ack);
            ack_cnt <= ack_cnt + 1;
            if (!$onehot(ack)) bad_oh <= bad_oh + 1;
        end
        if (div_start) begin
            start_cyc[start_cnt & 63] <= cyc;
            start_cnt <= start_cnt + 1;
        end
        if (rsp_valid) begin
            rsp_cyc[rsp_cnt & 63] <= cyc;
            rid_log[rsp_cnt & 63] <= rsp_id;
            q_log[rsp_cnt & 63]   <= rsp_quotient;
            r_log[rsp_cnt & 63]   <= rsp_remainder;
            err_log[rsp_cnt & 63] <= rsp_err;
            rsp_cnt <= rsp_cnt + 1;
        end
        if (ack != '0 && rsp_valid) overlap <= overlap + 1;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_dividend[i*WIDTH +: WIDTH] = a;
        req_divisor[i*WIDTH +: WIDTH]  = b;
    endtask

    task automatic wait_rsp(input int target, input bit drop, input int budget);
        int n = 0;
        while (rsp_cnt < target && n < budget) begin
            step(1);
            if (drop) req = req & ~ack;
            n++;
        end
        chk("rsp_timeout", 32'(rsp_cnt >= target), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, r, s, c, n;
        rst = 1'b1; req = '0; req_dividend = '0; req_divisor = '0;
        step(3);
        chk("rst_ctl", 32'({ack, div_start, rsp_valid, rsp_err, rsp_id, div_dividend, div_divisor}), 32'd0);
        chk("rst_rsp", 32'({rsp_quotient, rsp_remainder}), 32'd0);
        rst = 1'b0;
        step(2);

        // Round robin with all four held high: 0,1,2,3,0 back to back.
        set_op(0, 8'd200, 8'd10); set_op(1, 8'd99, 8'd4);
        set_op(2, 8'd250, 8'd16); set_op(3, 8'd77, 8'd9);
        req = 4'b1111;
        wait_rsp(5, 1'b0, 200);
        req = '0;
        chk("rr_g0", 32'(gnt_log[0]), 0); chk("rr_g1", 32'(gnt_log[1]), 1);
        chk("rr_g2", 32'(gnt_log[2]), 2); chk("rr_g3", 32'(gnt_log[3]), 3);
        chk("rr_g4", 32'(gnt_log[4]), 0);
        chk("rr_id3", 32'(rid_log[3]), 3);
        chk("rr_q0", 32'({q_log[0], r_log[0]}), 32'({8'd20, 8'd0}));
        chk("rr_q1", 32'({q_log[1], r_log[1]}), 32'({8'd24, 8'd3}));
        chk("rr_q2", 32'({q_log[2], r_log[2]}), 32'({8'd15, 8'd10}));
        chk("rr_q3", 32'({q_log[3], r_log[3]}), 32'({8'd8, 8'd5}));
        chk("b2b_gap", ack_cyc[1] - rsp_cyc[0], 2);
        step(3);

        // Single request 100/7 on client 2, with latency checks.
        set_op(2, 8'd100, 8'd7);
        a = ack_cnt; s = start_cnt; r = rsp_cnt; c = cyc;
        req = 4'b0100;
        wait_rsp(r + 1, 1'b1, 100);
        chk("t1_gnt", 32'(gnt_log[a]), 2);
        chk("t1_req2ack", ack_cyc[a] - c, 1);
        chk("t1_ack2start", start_cyc[s] - ack_cyc[a], 1);
        chk("t1_rdy2rsp", rsp_cyc[r] - ready_rise, 1);
        chk("t1_rsp", 32'({rid_log[r], q_log[r], r_log[r], err_log[r]}),
            32'({2'd2, 8'd14, 8'd2, 1'b0}));
        step(1);
        chk("t1_pulse", 32'(rsp_valid), 0);
        chk("t1_hold", 32'({rsp_quotient, rsp_remainder, div_dividend, div_divisor}),
            32'({8'd14, 8'd2, 8'd100, 8'd7}));
        step(2);

        // Pointer at 2 with req 1001: grant 3 first, then wrap to 0.
        a = ack_cnt; r = rsp_cnt;
        req = 4'b1001;
        wait_rsp(r + 2, 1'b0, 200);
        req = '0;
        chk("wrap_g3", 32'(gnt_log[a]), 3);
        chk("wrap_g0", 32'(gnt_log[a + 1]), 0);
        chk("wrap_q", 32'({q_log[r], q_log[r + 1]}), 32'({8'd8, 8'd20}));
        step(3);

        // Divider reported busy: no grant until ready returns.
        set_op(1, 8'd63, 8'd8);
        force_busy = 1'b1;
        a = ack_cnt; r = rsp_cnt;
        req = 4'b0010;
        step(6);
        chk("busy_noack", ack_cnt - a, 0);
        force_busy = 1'b0; c = cyc;
        wait_rsp(r + 1, 1'b1, 100);
        chk("busy_ack_lat", ack_cyc[a] - c, 1);
        chk("busy_rsp", 32'({rid_log[r], q_log[r], r_log[r]}), 32'({2'd1, 8'd7, 8'd7}));
        step(3);

        // Reset while waiting for the divider to finish.
        set_op(0, 8'd90, 8'd9);
        req = 4'b0001; n = 0;
        while (div_ready && n < 30) begin step(1); req = req & ~ack; n++; end
        chk("rst_busy_seen", 32'(div_ready), 0);
        step(1);
        rst = 1'b1; #1;
        chk("midrst_ctl", 32'({ack, div_start, rsp_valid, rsp_err, rsp_id, div_dividend, div_divisor}), 32'd0);
        chk("midrst_rsp", 32'({rsp_quotient, rsp_remainder}), 32'd0);
        step(1);
        rst = 1'b0; req = '0;
        r = rsp_cnt;
        step(LAT + 6);
        chk("midrst_dropped", rsp_cnt - r, 0);
        set_op(0, 8'd30, 8'd4);
        a = ack_cnt;
        req = 4'b0011;
        wait_rsp(r + 2, 1'b1, 200);
        chk("postrst_g0", 32'(gnt_log[a]), 0);
        chk("postrst_g1", 32'(gnt_log[a + 1]), 1);
        chk("postrst_r0", 32'({rid_log[r], q_log[r], r_log[r]}), 32'({2'd0, 8'd7, 8'd2}));
        step(3);

        // Zero divisor on client 0.
        set_op(0, 8'd55, 8'd0);
        a = ack_cnt; s = start_cnt; r = rsp_cnt;
        req = 4'b0001;
        wait_rsp(r + 1, 1'b1, 100);
`ifdef DIV_ZERO_BYPASS_EN
        chk("dz_nostart", start_cnt - s, 0);
        chk("dz_lat", rsp_cyc[r] - ack_cyc[a], 1);
        chk("dz_rsp", 32'({q_log[r], r_log[r], err_log[r]}), 32'({8'hFF, 8'd55, 1'b1}));
`else
        chk("dz_start", start_cnt - s, 1);
        chk("dz_rsp", 32'({q_log[r], r_log[r], err_log[r]}), 32'({8'hFF, 8'd55, 1'b0}));
`endif
        step(3);

        // Divider ignores the first start: re-pulse after four busy-wait cycles.
        set_op(2, 8'd250, 8'd16);
        stuck = 1'b1;
        a = ack_cnt; s = start_cnt; r = rsp_cnt; n = 0;
        req = 4'b0100;
        while (start_cnt < s + 2 && n < 40) begin step(1); req = req & ~ack; n++; end
        stuck = 1'b0;
        wait_rsp(r + 1, 1'b1, 100);
        chk("reissue_cnt", start_cnt - s, 2);
        chk("reissue_gap", start_cyc[s + 1] - start_cyc[s], 5);
        chk("reissue_1ack", ack_cnt - a, 1);
        chk("reissue_rsp", 32'({rid_log[r], q_log[r], r_log[r]}), 32'({2'd2, 8'd15, 8'd10}));

        chk("ack_rsp_overlap", overlap, 0);
        chk("ack_onehot", bad_oh, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
